// File: rtl/adder_subtractor_pkg.sv
// Shared constants for the adder/subtractor datapath: mode encodings and default width.
package adder_subtractor_pkg;

   localparam logic MODE_ADD     = 1'b0;
   localparam logic MODE_SUB     = 1'b1;
   localparam int   ADDSUB_WIDTH = 4;

endpackage : adder_subtractor_pkg

// File: rtl/adder_subtractor_full_adder.sv
// One-bit full adder; the top level chains WIDTH of these into a ripple-carry adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/adder_subtractor.sv
// Registered two's-complement adder/subtractor over a ripple-carry chain.
// Optional signed overflow output is built when ADDSUB_OVERFLOW_EN is defined.
module adder_subtractor
   import adder_subtractor_pkg::*;
#(
   parameter int WIDTH = ADDSUB_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             mode,
   output logic [WIDTH-1:0] sum,
`ifdef ADDSUB_OVERFLOW_EN
   output logic             overflow,
`endif
   output logic             cout
);

   // No handshake: A, B and mode are sampled on every rising edge and the
   // result is valid from just after that edge until the next one.

   logic [WIDTH-1:0] b_x;
   logic [WIDTH-1:0] s_next;
   logic [WIDTH:0]   carry;

   // Subtraction is A + ~B + 1, so mode both inverts B and supplies the +1.
   assign b_x      = B ^ {WIDTH{mode}};
   assign carry[0] = (mode == MODE_SUB);

   for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
      full_adder u_fa (
         .a    (A[i]),
         .b    (b_x[i]),
         .cin  (carry[i]),
         .s    (s_next[i]),
         .cout (carry[i+1])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum  <= '0;
         cout <= 1'b0;
      end else begin
         sum  <= s_next;
         cout <= carry[WIDTH];
      end
   end

`ifdef ADDSUB_OVERFLOW_EN
   // Signed overflow: carry into the MSB disagrees with carry out of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overflow <= 1'b0;
      else        overflow <= carry[WIDTH-1] ^ carry[WIDTH];
   end
`endif

endmodule : adder_subtractor

// File: tb/tb_adder_subtractor.sv
// Self-checking bench for adder_subtractor (WIDTH = 4), scoreboard-driven.
module tb_adder_subtractor;

   localparam int WIDTH = 4;
   localparam int W     = WIDTH + 1;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             mode;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef ADDSUB_OVERFLOW_EN
   logic             overflow;
`endif

   logic [W-1:0] exp_q[$];
   logic         ov_q[$];
   int           checks;
   int           errors;

   adder_subtractor #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .A        (A),
      .B        (B),
      .mode     (mode),
      .sum      (sum),
`ifdef ADDSUB_OVERFLOW_EN
      .overflow (overflow),
`endif
      .cout     (cout)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] model_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic m);
      int   r;
      logic c;
      if (!m) begin
         r = int'(a) + int'(b);
         c = (r > 15);
      end else begin
         r = int'(a) - int'(b);
         c = (a >= b);
      end
      model_res = {c, r[WIDTH-1:0]};
   endfunction

   function automatic logic model_ov(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic m);
      int sa;
      int sb;
      int r;
      sa = a[WIDTH-1] ? int'(a) - 16 : int'(a);
      sb = b[WIDTH-1] ? int'(b) - 16 : int'(b);
      r  = m ? sa - sb : sa + sb;
      model_ov = (r > 7) || (r < -8);
   endfunction

   // ---------------- driver ----------------
   task automatic drive_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic m);
      @(negedge clk);
      A    = a;
      B    = b;
      mode = m;
      exp_q.push_back(model_res(a, b, m));
      ov_q.push_back(model_ov(a, b, m));
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [W-1:0] exp;
      logic         exp_ov;
      rst_n = 1'b0;
      A = 4'd7; B = 4'd3; mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({cout, sum} !== '0) begin
         errors++;
         $display("FAIL reset_hold: got cout=%0b sum=%0d, want cout=0 sum=0", cout, sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive_op(4'd7, 4'd3, 1'b0);
      @(posedge clk);
      #1;
      exp    = exp_q.pop_front();
      exp_ov = ov_q.pop_front();
      checks++;
      if ({cout, sum} !== exp) begin
         errors++;
         $display("FAIL reset_release: got cout=%0b sum=%0d, want cout=%0b sum=%0d",
                  cout, sum, exp[W-1], exp[WIDTH-1:0]);
      end
`ifdef ADDSUB_OVERFLOW_EN
      checks++;
      if (overflow !== exp_ov) begin
         errors++;
         $display("FAIL reset_release_ov: got %0b want %0b", overflow, exp_ov);
      end
`endif
   endtask

   task automatic test_directed();
      logic [WIDTH-1:0] ta[7] = '{4'd3, 4'd15, 4'd3, 4'd4, 4'd2, 4'd7, 4'd0};
      logic [WIDTH-1:0] tb[7] = '{4'd2, 4'd1,  4'd2, 4'd4, 4'd4, 4'd1, 4'd0};
      logic             tm[7] = '{1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [W-1:0]     exp;
      logic             exp_ov;
      for (int i = 0; i < 7; i++) begin
         drive_op(ta[i], tb[i], tm[i]);
         @(posedge clk);
         #1;
         exp    = exp_q.pop_front();
         exp_ov = ov_q.pop_front();
         checks++;
         if ({cout, sum} !== exp) begin
            errors++;
            $display("FAIL directed_%0d (A=%0d B=%0d mode=%0b): got cout=%0b sum=%0d, want cout=%0b sum=%0d",
                     i, ta[i], tb[i], tm[i], cout, sum, exp[W-1], exp[WIDTH-1:0]);
         end
`ifdef ADDSUB_OVERFLOW_EN
         checks++;
         if (overflow !== exp_ov) begin
            errors++;
            $display("FAIL directed_ov_%0d: got %0b want %0b", i, overflow, exp_ov);
         end
`endif
      end
   endtask

   task automatic test_hold();
      logic [W-1:0] exp;
      logic         exp_ov;
      drive_op(4'd9, 4'd5, 1'b0);
      @(posedge clk);
      #1;
      exp    = exp_q.pop_front();
      exp_ov = ov_q.pop_front();
      #2;
      A = 4'd1; B = 4'd1; mode = 1'b1;
      #1;
      checks++;
      if ({cout, sum} !== exp) begin
         errors++;
         $display("FAIL hold_between_edges: got cout=%0b sum=%0d, want cout=%0b sum=%0d",
                  cout, sum, exp[W-1], exp[WIDTH-1:0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] exp;
      logic         exp_ov;
      for (int i = 0; i < 10; i++) begin
         drive_op(4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)), (i >= 5));
         @(posedge clk);
         #1;
         exp    = exp_q.pop_front();
         exp_ov = ov_q.pop_front();
         checks++;
         if ({cout, sum} !== exp) begin
            errors++;
            $display("FAIL sweep_%0d (A=%0d B=%0d mode=%0b): got cout=%0b sum=%0d, want cout=%0b sum=%0d",
                     i, A, B, mode, cout, sum, exp[W-1], exp[WIDTH-1:0]);
         end
`ifdef ADDSUB_OVERFLOW_EN
         checks++;
         if (overflow !== exp_ov) begin
            errors++;
            $display("FAIL sweep_ov_%0d: got %0b want %0b", i, overflow, exp_ov);
         end
`endif
      end
   endtask

   task automatic test_async_reset();
      logic [W-1:0] exp;
      logic         exp_ov;
      drive_op(4'd3, 4'd2, 1'b0);
      @(posedge clk);
      #1;
      exp    = exp_q.pop_front();
      exp_ov = ov_q.pop_front();
      checks++;
      if ({cout, sum} !== exp) begin
         errors++;
         $display("FAIL pre_reset: got cout=%0b sum=%0d, want cout=%0b sum=%0d",
                  cout, sum, exp[W-1], exp[WIDTH-1:0]);
      end
      // Next operation is in flight when reset lands mid-cycle.
      drive_op(4'd15, 4'd1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      ov_q.delete();
      checks++;
      if ({cout, sum} !== '0) begin
         errors++;
         $display("FAIL async_reset: got cout=%0b sum=%0d, want cout=0 sum=0", cout, sum);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({cout, sum} !== '0) begin
         errors++;
         $display("FAIL reset_held_edge: got cout=%0b sum=%0d, want cout=0 sum=0", cout, sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive_op(4'd1, 4'd3, 1'b1);
      @(posedge clk);
      #1;
      exp    = exp_q.pop_front();
      exp_ov = ov_q.pop_front();
      checks++;
      if ({cout, sum} !== exp) begin
         errors++;
         $display("FAIL post_reset: got cout=%0b sum=%0d, want cout=%0b sum=%0d",
                  cout, sum, exp[W-1], exp[WIDTH-1:0]);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      A      = '0;
      B      = '0;
      mode   = 1'b0;
      test_reset();
      test_directed();
      test_hold();
      test_back_to_back();
      test_async_reset();
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_adder_subtractor
